mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//   Word-addressed memory target that answers fetch, load and store requests from a multi-cycle
//   processor core over a valid/ready request channel and a valid/ready response channel.
//   Sits between the core and its instruction or data storage.
//   A programmable access latency lets the core's multi-cycle FSM be exercised against a slow memory.
//   One request is outstanding at a time.
// PARAMETERS
//   ADDR_W       8   request address width in bits (word address)
//   DATA_W       32  data word width in bits
//   DEPTH        16  number of storage words, valid addresses 0..DEPTH-1
//   WAIT_CYCLES  2   extra cycles between request accept and storage access (0..255)
// PORTS
//   clk        in   1       rising-edge clock
//   rst        in   1       asynchronous reset, active-high
//   req_valid  in   1       request present
//   req_ready  out  1       responder can accept a request
//   req_we     in   1       1 = store, 0 = load/fetch
//   req_addr   in   ADDR_W  word address
//   req_wdata  in   DATA_W  store data
//   resp_valid out  1       response present
//   resp_ready in   1       core accepts response
//   resp_rdata out  DATA_W  load data; 0 for stores and errors
//   resp_err   out  1       address out of range (addr >= DEPTH)
// BEHAVIOUR
//   Reset
//     rst=1 forces state=IDLE; req_ready=0 while rst is high.
//     Reset values: resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0.
//     Storage contents are NOT reset and survive reset.
//   FSM states: IDLE, WAIT, RESP.
//   IDLE
//     req_ready=1, resp_valid=0.
//     Edge with req_valid=1 latches req_we, req_addr and req_wdata, loads cnt=WAIT_CYCLES,
//     and moves to WAIT.
//   WAIT
//     req_ready=0.
//     cnt!=0: cnt decrements each edge.
//     cnt==0: the access is performed on that edge and the state moves to RESP.
//   Access rules
//     In-range store: the word is written, resp_rdata=0, resp_err=0.
//     In-range load: resp_rdata=mem[addr], resp_err=0.
//     Out of range: no write, resp_rdata=0, resp_err=1.
//   RESP
//     resp_valid=1; resp_rdata and resp_err are held stable until the edge with resp_ready=1.
//     That edge moves to IDLE with resp_valid=0. req_ready=0 throughout RESP.
//   Latency: the request handshake at edge E0 gives resp_valid=1 after edge E0+WAIT_CYCLES+1.
//   Throughput: one request per WAIT_CYCLES+3 cycles minimum (handshake, wait, response, IDLE).
//   Ordering: a load issued after a store to the same address returns the stored data.
//   No combinational path from any input to any output; req_ready is decoded from state only.
//   Width: addresses are compared unsigned against DEPTH; no address wrap-around.
//   Reset mid-operation
//     A store still in WAIT is discarded and memory is unchanged.
//     A response pending in RESP is dropped.
//   resp_ready=1 outside RESP is ignored. req_valid is ignored outside IDLE; the core must hold it.
// TESTING
//   1. WAIT_CYCLES=2: store addr 3 data 0x0000_00F6, then load addr 3
//      -> rdata=0x0000_00F6, err=0, resp_valid 3 cycles after each accept.
//   2. Load addr 5 with resp_ready=0 for 4 cycles
//      -> resp_valid, rdata and err stay stable, req_ready=0; IDLE one cycle after resp_ready=1.
//   3. Load addr 16 (DEPTH=16) and store addr 200
//      -> err=1, rdata=0; a load of addr 0 afterwards returns its previous value.
//   4. Store 0xAA to addr 2, then a store of 0x55 to addr 2 with rst pulsed during WAIT
//      -> FSM returns to IDLE, resp_valid=0, a reload of addr 2 returns 0xAA.
//   5. WAIT_CYCLES=0: back-to-back loads with resp_ready tied to 1
//      -> resp_valid one cycle after each accept, accepts spaced exactly 3 cycles apart.
//   6. Preload addrs 0..2 with -20, 10, 2 via stores, then load 0..2
//      -> returns 0xFFFF_FFEC, 0x0000_000A, 0x0000_0002.

Source files
------------

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Word-addressed memory target for a multi-cycle core. Accepts one fetch,
//   load or store request at a time over a valid/ready request channel,
//   waits WAIT_CYCLES extra cycles to model slow storage, performs the access
//   and presents the result on a valid/ready response channel.
//
//   Ports
//     clk, rst             rising-edge clock, asynchronous active-high reset
//     req_valid/req_ready  request handshake (req_ready registered, from state)
//     req_we               1 = store, 0 = load/fetch
//     req_addr             word address (unsigned, no wrap-around)
//     req_wdata            store data
//     resp_valid/ready     response handshake
//     resp_rdata           load data, 0 for stores and errors
//     resp_err             address out of range (addr >= DEPTH)
//
//   Storage is not reset, so its contents survive a reset pulse.
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [7:0]      WAIT_L  = 8'(WAIT_CYCLES);

    // Unsigned range check; the extra MSB keeps DEPTH == 2**ADDR_W representable.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < DEPTH_L);
    endfunction

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                req_ready_q, req_ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic                resp_err_q, resp_err_d;

    logic                access_s;
    logic                in_range_s;
    logic                mem_we_s;
    logic [IDX_W-1:0]    mem_idx_s;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    // State, latched request and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Storage array; deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_idx_s] <= wdata_q;
        end else begin
            mem_q[mem_idx_s] <= mem_q[mem_idx_s];
        end
    end

    // Next-state logic and request capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                // Gate on the registered ready so nothing is taken in the
                // first cycle after reset release, while req_ready is still 0.
                if (req_valid && req_ready_q) begin
                    state_d = S_WAIT;
                    cnt_d   = WAIT_L;
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode, storage access and response data.
    always_comb begin
        access_s     = (state_q == S_WAIT) && (cnt_q == 8'd0);
        in_range_s   = addr_in_range(addr_q);
        mem_idx_s    = addr_q[IDX_W-1:0];
        mem_we_s     = access_s && we_q && in_range_s;
        // Outputs are registered from the next state so they line up with it.
        req_ready_d  = (state_d == S_IDLE);
        resp_valid_d = (state_d == S_RESP);
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        if (access_s) begin
            if (!in_range_s) begin
                resp_rdata_d = '0;
                resp_err_d   = 1'b1;
            end else if (we_q) begin
                resp_rdata_d = '0;
                resp_err_d   = 1'b0;
            end else begin
                resp_rdata_d = mem_q[mem_idx_s];
                resp_err_d   = 1'b0;
            end
        end else if ((state_q == S_RESP) && resp_ready) begin
            resp_rdata_d = '0;
            resp_err_d   = 1'b0;
        end else begin
            resp_rdata_d = resp_rdata_q;
            resp_err_d   = resp_err_q;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//   Self-checking bench for mem_responder. A WAIT_CYCLES=2 instance runs the
//   directed scenarios plus a randomized request stream against an array
//   model of the storage; a WAIT_CYCLES=0 instance runs a back-to-back load
//   stream with resp_ready tied high to check spacing and latency.
// -----------------------------------------------------------------------------
module tb_mem_responder;

    localparam int W = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata, resp_rdata;

    logic        z_valid, z_ready, z_we, z_resp_valid, z_resp_ready, z_err;
    logic [7:0]  z_addr;
    logic [31:0] z_wdata, z_rdata;

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned cyc = 0;

    logic [31:0] ref_mem [16];
    logic [31:0] z_mem   [16];

    mem_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(16), .WAIT_CYCLES(W)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    mem_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(16), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(z_valid), .req_ready(z_ready), .req_we(z_we),
        .req_addr(z_addr), .req_wdata(z_wdata),
        .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
        .resp_rdata(z_rdata), .resp_err(z_err)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference behaviour: in range -> store writes / load reads, else error.
    task automatic model_op(input logic we, input logic [7:0] addr, input logic [31:0] wd,
                            output logic [31:0] exp_d, output logic exp_e);
        int a;
        a = int'(addr);
        if (a < 16) begin
            exp_e = 1'b0;
            if (we) begin
                ref_mem[a] = wd;
                exp_d = 32'd0;
            end else begin
                exp_d = ref_mem[a];
            end
        end else begin
            exp_e = 1'b1;
            exp_d = 32'd0;
        end
    endtask

    // One complete transaction on the main instance; entered and left at a negedge.
    task automatic do_req(input string tag, input logic we, input logic [7:0] addr,
                          input logic [31:0] wd, input int hold, output logic [31:0] got);
        int          n;
        logic [31:0] exp_d;
        logic        exp_e;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_rdy"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        // Scramble the payload: the latched copy must be used from here on.
        req_valid = 1'b0;
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = 8'($urandom);
        req_wdata = $urandom;
        model_op(we, addr, wd, exp_d, exp_e);
        check_eq({tag, "_busy"}, 32'({resp_valid, req_ready}), 32'd0);
        n = 0;
        while (!resp_valid && n < 50) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_lat"}, 32'(n), 32'(W + 1));
        check_eq({tag, "_data"}, resp_rdata, exp_d);
        check_eq({tag, "_err"}, 32'(resp_err), 32'(exp_e));
        got = resp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq({tag, "_hold"}, 32'({resp_valid, req_ready, resp_err}), 32'({2'b10, exp_e}));
            check_eq({tag, "_hdat"}, resp_rdata, exp_d);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        check_eq({tag, "_done"}, 32'({resp_valid, req_ready}), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] got;
        logic [7:0]  addr;
        logic        we;
        logic        zwe   [12];
        logic [7:0]  zaddr [12];
        logic [31:0] zwd   [12];
        logic [31:0] exp_d;
        logic        exp_e;
        int unsigned t, prev;
        int          n;

        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 8'd0; req_wdata = 32'd0; resp_ready = 1'b0;
        z_valid = 1'b0; z_we = 1'b0; z_addr = 8'd0; z_wdata = 32'd0; z_resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_out", 32'({req_ready, resp_valid, resp_err}), 32'd0);
        check_eq("rst_dat", resp_rdata, 32'd0);
        check_eq("rst_out0", 32'({z_ready, z_resp_valid, z_err}), 32'd0);
        rst = 1'b0;

        // Give every word a known value so any later load has an expectation.
        for (int i = 0; i < 16; i++) begin
            do_req("init", 1'b1, 8'(i), $urandom, 0, got);
        end

        // Store then load the same address.
        do_req("t1_st", 1'b1, 8'd3, 32'h0000_00F6, 0, got);
        do_req("t1_ld", 1'b0, 8'd3, 32'd0, 0, got);
        check_eq("t1_val", got, 32'h0000_00F6);

        // Response back-pressure.
        do_req("t2", 1'b0, 8'd5, 32'd0, 4, got);

        // Out-of-range accesses must not disturb storage.
        do_req("t3_ld16", 1'b0, 8'd16, 32'd0, 1, got);
        do_req("t3_st200", 1'b1, 8'd200, 32'hDEAD_BEEF, 0, got);
        do_req("t3_st255", 1'b1, 8'd255, 32'h1234_5678, 0, got);
        do_req("t3_ld0", 1'b0, 8'd0, 32'd0, 0, got);
        do_req("t3_ld15", 1'b0, 8'd15, 32'd0, 0, got);

        // Reset during WAIT drops a pending store.
        do_req("t4_st", 1'b1, 8'd2, 32'h0000_00AA, 0, got);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'd2; req_wdata = 32'h0000_0055;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("t4_wait", 32'({resp_valid, req_ready}), 32'd0);
        rst = 1'b1;
        #1;
        check_eq("t4_inrst", 32'({resp_valid, req_ready, resp_err}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("t4_post", 32'({resp_valid, resp_err}), 32'd0);
        check_eq("t4_pdat", resp_rdata, 32'd0);
        do_req("t4_ld", 1'b0, 8'd2, 32'd0, 0, got);
        check_eq("t4_val", got, 32'h0000_00AA);

        // Signed values round-trip as raw words.
        do_req("t6_s0", 1'b1, 8'd0, 32'(-20), 0, got);
        do_req("t6_s1", 1'b1, 8'd1, 32'd10, 0, got);
        do_req("t6_s2", 1'b1, 8'd2, 32'd2, 0, got);
        do_req("t6_l0", 1'b0, 8'd0, 32'd0, 0, got);
        check_eq("t6_v0", got, 32'hFFFF_FFEC);
        do_req("t6_l1", 1'b0, 8'd1, 32'd0, 0, got);
        check_eq("t6_v1", got, 32'h0000_000A);
        do_req("t6_l2", 1'b0, 8'd2, 32'd0, 0, got);
        check_eq("t6_v2", got, 32'h0000_0002);

        // Randomized mix of loads, stores and out-of-range addresses.
        for (int i = 0; i < 40; i++) begin
            we   = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
            do_req("rnd", we, addr, $urandom, int'($urandom_range(0, 3)), got);
        end

        // Zero-wait instance: back-to-back stream with resp_ready tied high.
        for (int i = 0; i < 12; i++) begin
            zwe[i]   = (i < 4);
            zaddr[i] = (i < 4) ? 8'(i) : 8'($urandom_range(0, 3));
            zwd[i]   = $urandom;
        end
        zaddr[11] = 8'd99;
        z_resp_ready = 1'b1;
        z_valid = 1'b1; z_we = zwe[0]; z_addr = zaddr[0]; z_wdata = zwd[0];
        prev = 0;
        for (int i = 0; i < 12; i++) begin
            n = 0;
            while (!z_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            check_eq("t5_rdy", 32'(z_ready), 32'd1);
            @(posedge clk);
            @(negedge clk);
            t = cyc;
            if (i > 0) check_eq("t5_gap", t - prev, 32'd3);
            prev = t;
            check_eq("t5_busy", 32'({z_resp_valid, z_ready}), 32'd0);
            if (int'(zaddr[i]) < 16) begin
                exp_e = 1'b0;
                if (zwe[i]) begin
                    z_mem[zaddr[i][3:0]] = zwd[i];
                    exp_d = 32'd0;
                end else begin
                    exp_d = z_mem[zaddr[i][3:0]];
                end
            end else begin
                exp_e = 1'b1;
                exp_d = 32'd0;
            end
            if (i < 11) begin
                z_we = zwe[i+1]; z_addr = zaddr[i+1]; z_wdata = zwd[i+1];
            end else begin
                z_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            check_eq("t5_vld", 32'(z_resp_valid), 32'd1);
            check_eq("t5_data", z_rdata, exp_d);
            check_eq("t5_err", 32'(z_err), 32'(exp_e));
        end
        z_resp_ready = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
